// File: rtl/common.sv
// Shared types and helpers for the flash boot loader.
package common;

  typedef enum logic [1:0] {LOAD, DRAIN, RUN} loader_state_t;

  // log2 of bytes per word: number of low address bits that must be zero.
  function automatic int word_offset(input int width);
    return $clog2(width / 8);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head entry is read straight from storage so it
// only changes on clock edges.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: buffers host flash writes, retires them to core memory, and
// holds the core in reset until loading is done and the buffer has drained.
module mem_loader
  import common::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash_en,
  input  logic                  flash_burst,
  input  logic [WIDTH-1:0]      flash_addr,
  input  logic [WIDTH-1:0]      flash_data,
  output logic                  flash_ready,
  input  logic                  flash_done,
  input  logic                  flash_reload,
  output logic                  mem_wr_en,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]      mem_wr_data,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH-1:0] words_loaded,
  output logic                  err_overflow,
  output logic                  err_misaligned
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } loader_entry_t;

  localparam int                    EW    = $bits(loader_entry_t);
  localparam int                    OFS   = word_offset(WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << OFS) - 1);
  localparam logic [ADDR_WIDTH-1:0] WMAX  = '1;
  localparam int                    CW    = $clog2(FIFO_DEPTH) + 1;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, res_addr;
  logic                  in_load, misaligned, push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  loader_entry_t         wr_entry, head;

  // Host address bits above the memory window are intentionally dropped.
  generate
    if (WIDTH > ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^flash_addr[WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  assign in_load    = (state_q == LOAD);
  assign res_addr   = flash_burst ? base_q + STEP : flash_addr[ADDR_WIDTH-1:0];
  assign misaligned = |(res_addr & AMASK);
  assign flash_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push       = in_load && flash_en && !fifo_full && !misaligned;
  assign pop        = mem_wr_en && mem_wr_ready;
  assign wr_entry   = '{addr: res_addr, data: flash_data};

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mem_wr_en   = !fifo_empty;
  assign mem_wr_addr = head.addr;
  assign mem_wr_data = head.data;
  assign cpu_hold    = (state_q != RUN);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (flash_done)   state_d = DRAIN;
      DRAIN:   if (fifo_empty)   state_d = RUN;
      RUN:     if (flash_reload) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q         <= '0;
      words_loaded   <= '0;
      err_overflow   <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      if (state_q == RUN && flash_reload) begin
        base_q       <= '0;
        words_loaded <= '0;
      end else begin
        // Base tracks every resolved address in LOAD, dropped or not.
        if (in_load && flash_en) base_q <= res_addr;
        if (pop && words_loaded != WMAX) words_loaded <= words_loaded + 1'b1;
      end
      if (in_load && flash_en && !flash_ready)              err_overflow   <= 1'b1;
      if (in_load && flash_en && flash_ready && misaligned) err_misaligned <= 1'b1;
    end
  end

endmodule
